// File: rtl/seven_seg_scan_ctrl.sv
// seven_seg_scan_ctrl: time-multiplexed scan controller for a 4-digit 7-segment display.
// Latency: a write shows up at the next frame start; o_nibble is loaded one BLANK slot ahead of its SHOW slot.
// Backpressure: o_ready = !pending_full; a held i_valid waits until the next frame start frees the pending slot.
// Build option: define LEADING_ZERO_BLANK_EN to suppress leading zero digits (digit 0 is always shown).
module seven_seg_scan_ctrl #(
  parameter int CLKS_PER_DIGIT = 25000,
  parameter int BLANK_CLKS     = 250
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_enable,
  input  logic        i_valid,
  input  logic [15:0] i_value,
  output logic        o_ready,
  output logic [3:0]  o_nibble,
  output logic [3:0]  o_digit_sel_n,
  output logic        o_frame
);

  localparam int MAXC = (CLKS_PER_DIGIT > BLANK_CLKS) ? CLKS_PER_DIGIT : BLANK_CLKS;
  localparam int CW   = $clog2(MAXC);
  localparam logic [CW-1:0] BLANK_LOAD = CW'(BLANK_CLKS - 1);
  localparam logic [CW-1:0] SHOW_LOAD  = CW'(CLKS_PER_DIGIT - 1);

  typedef enum logic [1:0] {S_IDLE, S_BLANK, S_SHOW} state_t;

  state_t          state_q;
  logic [CW-1:0]   cnt_q;
  logic [1:0]      idx_q;
  logic [15:0]     pending_q;
  logic            pending_full_q;
  logic [15:0]     displayed_q;
  logic [3:0]      nibble_q;
  logic [3:0]      sel_n_q;
  logic            frame_q;

  logic            frame_start;
  logic            accept;
  logic [15:0]     displayed_d;
  logic [1:0]      idx_d;
  logic [15:0]     nib_sh;
  logic [3:0]      nibble_d;
  logic [3:0]      sel_show;
`ifdef LEADING_ZERO_BLANK_EN
  logic [15:0]     lead_sh;
`endif

  assign o_ready       = !pending_full_q;
  assign o_nibble      = nibble_q;
  assign o_digit_sel_n = sel_n_q;
  assign o_frame       = frame_q;

  // Next-frame bookkeeping: frame start detection, the nibble for the upcoming BLANK and the select for SHOW.
  always_comb begin
    frame_start = i_enable &&
                  ((state_q == S_IDLE) ||
                   ((state_q == S_SHOW) && (cnt_q == '0) && (idx_q == 2'd3)));
    accept      = i_valid && !pending_full_q;
    // The frame-start copy must be visible to digit 0's nibble loaded on the same edge.
    displayed_d = (frame_start && pending_full_q) ? pending_q : displayed_q;
    idx_d       = (state_q == S_IDLE) ? 2'd0 : idx_q + 2'd1;
    nib_sh      = displayed_d >> {idx_d, 2'b00};
    nibble_d    = nib_sh[3:0];
    sel_show    = ~(4'b0001 << idx_q);
`ifdef LEADING_ZERO_BLANK_EN
    // Digits idx..3 all zero means this digit is a leading zero; digit 0 is never suppressed.
    lead_sh     = displayed_q >> {idx_q, 2'b00};
    if ((idx_q != 2'd0) && (lead_sh == 16'h0000)) sel_show = 4'hF;
`endif
  end

  // Scan FSM, write buffer and registered outputs.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q        <= S_IDLE;
      cnt_q          <= '0;
      idx_q          <= 2'd0;
      pending_q      <= 16'h0000;
      pending_full_q <= 1'b0;
      displayed_q    <= 16'h0000;
      nibble_q       <= 4'h0;
      sel_n_q        <= 4'hF;
      frame_q        <= 1'b0;
    end else begin
      frame_q <= 1'b0;

      if (frame_start && pending_full_q) begin
        displayed_q    <= pending_q;
        pending_full_q <= 1'b0;
      end else if (accept) begin
        pending_q      <= i_value;
        pending_full_q <= 1'b1;
      end

      case (state_q)
        S_IDLE: begin
          sel_n_q <= 4'hF;
          if (i_enable) begin
            state_q  <= S_BLANK;
            cnt_q    <= BLANK_LOAD;
            idx_q    <= 2'd0;
            nibble_q <= nibble_d;
            frame_q  <= 1'b1;
          end
        end
        S_BLANK: begin
          if (!i_enable) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            idx_q   <= 2'd0;
            sel_n_q <= 4'hF;
          end else if (cnt_q == '0) begin
            state_q <= S_SHOW;
            cnt_q   <= SHOW_LOAD;
            sel_n_q <= sel_show;
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
        S_SHOW: begin
          if (!i_enable) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            idx_q   <= 2'd0;
            sel_n_q <= 4'hF;
          end else if (cnt_q == '0) begin
            state_q  <= S_BLANK;
            cnt_q    <= BLANK_LOAD;
            idx_q    <= idx_d;
            nibble_q <= nibble_d;
            sel_n_q  <= 4'hF;
            frame_q  <= frame_start;
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
        default: begin
          state_q <= S_IDLE;
          cnt_q   <= '0;
          idx_q   <= 2'd0;
          sel_n_q <= 4'hF;
        end
      endcase
    end
  end

endmodule
